dfdd_frontend: RTL and testbench

Multi-channel input front end for the depth-from-defocus datapath. It converts `CHANNELS` unsigned 8-bit pixel samples per beat into the team's `1 + EXP_WIDTH + FRAC_WIDTH` floating-point format, for example the rho-plus and rho-minus planes. Each pixel's col/row tag travels with it, and the results are buffered in an output FIFO with valid/ready backpressure. It sits between the camera/uint8 stream and the dfdd core. The existing core interface has no flow control, carries exactly two uint8 planes and has no conversion stage; this block adds all three.

---
 rtl/dfdd_frontend.sv | 147 ++++++++++++++
 tb/tb_dfdd_frontend.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfdd_frontend.sv
`timescale 1ns/1ps
// dfdd_frontend: converts CHANNELS uint8 samples per beat into packed floats through a
// two-stage pipeline feeding a show-ahead output FIFO with valid/ready handshaking.
module dfdd_frontend #(
  parameter int EXP_WIDTH  = 5,
  parameter int FRAC_WIDTH = 10,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [CHANNELS*8-1:0]               pix_i,
  input  logic [15:0]                         col_i,
  input  logic [15:0]                         row_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic [CHANNELS*FP_WIDTH_REG-1:0]    fp_o,
  output logic [15:0]                         col_o,
  output logic [15:0]                         row_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [$clog2(FIFO_DEPTH):0]         level_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int FP_ALL  = CHANNELS * FP_WIDTH_REG;
  localparam int ENTRY_W = FP_ALL + 32;

  function automatic logic [2:0] msb_idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) r = 3'(b);
    end
    return r;
  endfunction

  // Shifting the MSB up to bit 7 leaves the remaining bits left-aligned; taking the top
  // FRAC_WIDTH bits of {below, zeros} pads or truncates toward zero as needed.
  function automatic logic [FP_WIDTH_REG-1:0] pack_fp(input logic [7:0] pix, input logic [2:0] p);
    logic [6:0]            below;
    logic [FRAC_WIDTH-1:0] frac;
    logic [EXP_WIDTH-1:0]  ex;
    below = 7'(pix << (3'd7 - p));
    frac  = FRAC_WIDTH'({below, {FRAC_WIDTH{1'b0}}} >> 7);
    ex    = EXP_WIDTH'(BIAS + int'(p));
    if (pix == 8'd0) return '0;
    return {1'b0, ex, frac};
  endfunction

  logic                     w_accept;
  logic [CHANNELS*3-1:0]    w_p;
  logic [FP_ALL-1:0]        w_fp;
  logic                     w_push;
  logic                     w_pop;
  logic [AW+1:0]            w_reserved;
  logic [ENTRY_W-1:0]       w_head;

  logic                     r_s1_valid;
  logic [CHANNELS*8-1:0]    r_s1_pix;
  logic [CHANNELS*3-1:0]    r_s1_p;
  logic [15:0]              r_s1_col;
  logic [15:0]              r_s1_row;
  logic                     r_s2_valid;
  logic [FP_ALL-1:0]        r_s2_fp;
  logic [15:0]              r_s2_col;
  logic [15:0]              r_s2_row;
  logic [ENTRY_W-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;

  // Entries still in the pipeline already own a FIFO slot, so S1/S2 never need to stall.
  assign w_reserved = (AW+2)'(r_count) + (AW+2)'(r_s1_valid) + (AW+2)'(r_s2_valid);
  assign ready_o    = w_reserved < (AW+2)'(FIFO_DEPTH);
  assign w_accept   = valid_i && ready_o;

  always_comb begin
    w_p = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_p[3*k +: 3] = msb_idx(pix_i[8*k +: 8]);
    end
  end

  always_comb begin
    w_fp = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_fp[FP_WIDTH_REG*k +: FP_WIDTH_REG] = pack_fp(r_s1_pix[8*k +: 8], r_s1_p[3*k +: 3]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_s1_pix <= pix_i;
      r_s1_p   <= w_p;
      r_s1_col <= col_i;
      r_s1_row <= row_i;
    end
    if (r_s1_valid) begin
      r_s2_fp  <= w_fp;
      r_s2_col <= r_s1_col;
      r_s2_row <= r_s1_row;
    end
  end

  assign w_push = r_s2_valid;
  assign w_pop  = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_s2_fp, r_s2_col, r_s2_row};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs read as zero while empty so reset leaves a clean, defined head.
  assign w_head  = r_mem[r_rd_ptr];
  assign valid_o = (r_count != '0);
  assign level_o = r_count;
  assign {fp_o, col_o, row_o} = valid_o ? w_head : '0;

endmodule

// File: tb/tb_dfdd_frontend.sv
`timescale 1ns/1ps
// Bench for dfdd_frontend: two configurations share one stimulus stream; a scoreboard
// per instance holds reference-converted beats and checks every pop.
module tb_dfdd_frontend;

  typedef struct {
    logic [63:0] fp;
    logic [15:0] col;
    logic [15:0] row;
  } sb_t;

  typedef struct {
    logic [31:0] pix;
    logic [63:0] fp_m;
    logic [31:0] fp_t;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] pix_i = '0;
  logic [15:0] col_i = '0;
  logic [15:0] row_i = '0;

  logic        ready_o_m, valid_o_m;
  logic [63:0] fp_o_m;
  logic [15:0] col_o_m, row_o_m;
  logic [3:0]  level_o_m;
  logic        ready_o_t, valid_o_t;
  logic [31:0] fp_o_t;
  logic [15:0] col_o_t, row_o_t;
  logic [2:0]  level_o_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop_m = 0;
  int n_pop_t = 0;
  int lvl_viol = 0;
  logic acc_m, acc_t;
  logic hold_m = 1'b0, hold_t = 1'b0;
  logic [63:0] sav_fp_m;
  logic [31:0] sav_fp_t;
  logic [15:0] sav_col_m, sav_row_m, sav_col_t, sav_row_t;
  sb_t q_m[$];
  sb_t q_t[$];
  vec_t tbl[4];

  always #5 clk = ~clk;

  dfdd_frontend #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .CHANNELS(4), .FIFO_DEPTH(8)) u_dut_m (
    .clk_i(clk), .rst_i(rst_i), .pix_i(pix_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .ready_o(ready_o_m), .fp_o(fp_o_m), .col_o(col_o_m),
    .row_o(row_o_m), .valid_o(valid_o_m), .ready_i(ready_i), .level_o(level_o_m));

  dfdd_frontend #(.EXP_WIDTH(4), .FRAC_WIDTH(3), .CHANNELS(4), .FIFO_DEPTH(4)) u_dut_t (
    .clk_i(clk), .rst_i(rst_i), .pix_i(pix_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .ready_o(ready_o_t), .fp_o(fp_o_t), .col_o(col_o_t),
    .row_o(row_o_t), .valid_o(valid_o_t), .ready_i(ready_i), .level_o(level_o_t));

  function automatic logic [31:0] ref_fp(input int e, input int f, input logic [7:0] v);
    int p, rem, frac;
    if (v == 8'd0) return 32'd0;
    p = 7;
    while (!v[p]) p--;
    rem  = int'(v) - (1 << p);
    frac = (f >= p) ? (rem << (f - p)) : (rem >> (p - f));
    return 32'(((((1 << (e - 1)) - 1) + p) << f) | frac);
  endfunction

  function automatic logic [63:0] exp_pix(input int e, input int f, input logic [31:0] px);
    logic [63:0] r;
    int fw;
    fw = 1 + e + f;
    r  = '0;
    for (int k = 0; k < 4; k++) r = r | (64'(ref_fp(e, f, px[8*k +: 8])) << (fw * k));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_miss(input string name, input logic [15:0] col);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output col %0h with no beat outstanding", name, col);
  endtask

  task automatic evaluate();
    sb_t e;
    acc_m = 1'b0;
    acc_t = 1'b0;
    if (rst_i) begin
      q_m.delete();
      q_t.delete();
      hold_m = 1'b0;
      hold_t = 1'b0;
      return;
    end
    if (hold_m) begin
      chk("hold_fp_m", fp_o_m, sav_fp_m);
      chk("hold_col_m", 64'(col_o_m), 64'(sav_col_m));
      chk("hold_row_m", 64'(row_o_m), 64'(sav_row_m));
    end
    if (hold_t) begin
      chk("hold_fp_t", 64'(fp_o_t), 64'(sav_fp_t));
      chk("hold_col_t", 64'(col_o_t), 64'(sav_col_t));
    end
    if (level_o_m > 4'd8) lvl_viol++;
    if (level_o_t > 3'd4) lvl_viol++;
    if (valid_i && ready_o_m) begin
      acc_m = 1'b1;
      q_m.push_back('{fp: exp_pix(5, 10, pix_i), col: col_i, row: row_i});
    end
    if (valid_i && ready_o_t) begin
      acc_t = 1'b1;
      q_t.push_back('{fp: exp_pix(4, 3, pix_i), col: col_i, row: row_i});
    end
    if (valid_o_m && ready_i) begin
      n_pop_m++;
      if (q_m.size() == 0) sb_miss("sb_extra_m", col_o_m);
      else begin
        e = q_m.pop_front();
        chk("sb_fp_m", fp_o_m, e.fp);
        chk("sb_col_m", 64'(col_o_m), 64'(e.col));
        chk("sb_row_m", 64'(row_o_m), 64'(e.row));
      end
    end
    if (valid_o_t && ready_i) begin
      n_pop_t++;
      if (q_t.size() == 0) sb_miss("sb_extra_t", col_o_t);
      else begin
        e = q_t.pop_front();
        chk("sb_fp_t", 64'(fp_o_t), e.fp);
        chk("sb_col_t", 64'(col_o_t), 64'(e.col));
        chk("sb_row_t", 64'(row_o_t), 64'(e.row));
      end
    end
    hold_m = valid_o_m && !ready_i;
    hold_t = valid_o_t && !ready_i;
    sav_fp_m = fp_o_m; sav_col_m = col_o_m; sav_row_m = row_o_m;
    sav_fp_t = fp_o_t; sav_col_t = col_o_t; sav_row_t = row_o_t;
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] px,
                      input logic [15:0] c, input logic [15:0] rw, input logic rdy);
    @(negedge clk);
    rst_i = r; valid_i = v; pix_i = px; col_i = c; row_i = rw; ready_i = rdy;
    #1;
    evaluate();
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q_m.size() == 0 && q_t.size() == 0) break;
      step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b1);
    end
    chk("drain_m", 64'(q_m.size()), 64'd0);
    chk("drain_t", 64'(q_t.size()), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid_m"}, 64'(valid_o_m), 64'd0);
    chk({tag, "_level_m"}, 64'(level_o_m), 64'd0);
    chk({tag, "_ready_m"}, 64'(ready_o_m), 64'd1);
    chk({tag, "_fp_m"}, fp_o_m, 64'd0);
    chk({tag, "_colrow_m"}, 64'({col_o_m, row_o_m}), 64'd0);
    chk({tag, "_valid_t"}, 64'(valid_o_t), 64'd0);
    chk({tag, "_level_t"}, 64'(level_o_t), 64'd0);
    chk({tag, "_ready_t"}, 64'(ready_o_t), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int idx, cyc, sent, pop0, rviol, gap;
    tbl[0] = '{pix: {8'd255, 8'd128, 8'd1, 8'd0},
               fp_m: {16'h5BF8, 16'h5800, 16'h3C00, 16'h0000}, fp_t: {8'h77, 8'h70, 8'h38, 8'h00}};
    tbl[1] = '{pix: {8'd0, 8'd1, 8'd9, 8'd255},
               fp_m: {16'h0000, 16'h3C00, 16'h4880, 16'h5BF8}, fp_t: {8'h00, 8'h38, 8'h51, 8'h77}};
    tbl[2] = '{pix: {8'd64, 8'd127, 8'd3, 8'd2},
               fp_m: {16'h5400, 16'h57F0, 16'h4200, 16'h4000}, fp_t: {8'h68, 8'h6F, 8'h44, 8'h40}};
    tbl[3] = '{pix: {8'd254, 8'd128, 8'd3, 8'd2},
               fp_m: {16'h5BF0, 16'h5800, 16'h4200, 16'h4000}, fp_t: {8'h77, 8'h70, 8'h44, 8'h40}};

    // Reset state; a beat offered during reset must not be taken.
    step(1'b1, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 16'h1234, 16'h5678, 1'b0);
    chk_idle("reset");
    step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
    chk("reset_no_accept", 64'(level_o_m), 64'd0);

    // Conversion table with latency check.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, tbl[i].pix, 16'(i), 16'(200 + i), 1'b0);
      chk("tbl_accept", 64'(acc_m), 64'd1);
      step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
      chk("lat_n1", 64'(valid_o_m), 64'd0);
      step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
      chk("lat_n2", 64'(valid_o_m), 64'd0);
      step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b1);
      chk("lat_n3", 64'(valid_o_m), 64'd1);
      chk("tbl_fp_m", fp_o_m, tbl[i].fp_m);
      chk("tbl_fp_t", 64'(fp_o_t), 64'(tbl[i].fp_t));
      chk("tbl_col", 64'(col_o_m), 64'(i));
      step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
      chk("tbl_level", 64'(level_o_m), 64'd0);
    end

    // Backpressure: 20 beats offered, downstream stalled for 30 cycles.
    idx = 0; cyc = 0; pop0 = n_pop_m;
    while (idx < 20 && cyc < 300) begin
      step(1'b0, 1'b1, {8'(idx * 37), 8'(idx * 11 + 3), 8'(idx), 8'(255 - idx)},
           16'(idx), 16'(idx + 500), cyc >= 30);
      if (acc_m) idx++;
      if (cyc == 30) begin
        chk("bp_accepted", 64'(idx), 64'd8);
        chk("bp_ready_low", 64'(ready_o_m), 64'd0);
        chk("bp_level", 64'(level_o_m), 64'd8);
      end
      if (cyc == 31) chk("bp_ready_rise", 64'(ready_o_m), 64'd1);
      cyc++;
    end
    chk("bp_all_sent", 64'(idx), 64'd20);
    drain();
    chk("bp_pops", 64'(n_pop_m - pop0), 64'd20);

    // Random valid/ready.
    sent = 0; cyc = 0; pop0 = n_pop_m;
    while (sent < 5000 && cyc < 40000) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom(), 16'(sent), 16'($urandom()),
           1'($urandom_range(0, 1)));
      if (acc_m) sent++;
      cyc++;
    end
    chk("rnd_sent", 64'(sent), 64'd5000);
    drain();
    chk("rnd_pops", 64'(n_pop_m - pop0), 64'd5000);
    chk("level_bound", 64'(lvl_viol), 64'd0);

    // Full rate on the depth-4 instance.
    rviol = 0; gap = 0; pop0 = n_pop_t;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, $urandom(), 16'(i), 16'(i ^ 16'h5555), 1'b1);
      if (!ready_o_t || !acc_t) rviol++;
      if (i >= 3 && !valid_o_t) gap++;
    end
    chk("fr_ready_t", 64'(rviol), 64'd0);
    chk("fr_gaps_t", 64'(gap), 64'd0);
    chk("fr_pops_t", 64'(n_pop_t - pop0), 64'd997);
    drain();

    // Reset with five buffered beats and both stages occupied.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, $urandom(), 16'(16'h9000 + i), 16'd7, 1'b0);
    step(1'b1, 1'b1, $urandom(), 16'h9999, 16'd7, 1'b0);
    chk("rst_pre_level", 64'(level_o_m), 64'd5);
    step(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0);
    chk_idle("midrst");
    pop0 = n_pop_m;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, $urandom(), 16'(16'hA000 + i), 16'(i), 1'b1);
    drain();
    chk("rst_post_pops", 64'(n_pop_m - pop0), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
